// File: rtl/seq_det_ctrl_if.sv
// rtl/seq_det_ctrl_if.sv - word input handshake between producer and serial pattern detector
interface seq_det_ctrl_if #(parameter int WORD_W = 8);
   logic              in_valid;
   logic [WORD_W-1:0] in_data;
   logic              in_ready;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/seq_det_ctrl.sv
// rtl/seq_det_ctrl.sv - word-fed serial pattern detector with saturating match counter
// Optional sticky match-count interrupt is built when SEQ_DET_IRQ_EN is defined.
module seq_det_ctrl #(
   parameter int WORD_W = 8,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cfg_we,
   input  logic [7:0]       cfg_pattern,
   input  logic [3:0]       cfg_len,
   input  logic             cfg_overlap,
   seq_det_ctrl_if.slave    in_if,
   output logic             det_pulse,
   output logic [CNT_W-1:0] match_cnt,
   output logic             busy
`ifdef SEQ_DET_IRQ_EN
   ,
   input  logic [CNT_W-1:0] irq_thresh,
   input  logic             irq_clr,
   output logic             irq
`endif
);
   localparam int               IDX_W   = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(WORD_W - 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t            state;
   logic [WORD_W-1:0] sreg;
   logic [IDX_W-1:0]  bit_idx;
   logic [7:0]        pattern;
   logic [3:0]        len;
   logic              overlap;
   logic [7:0]        hist;
   logic [3:0]        hist_cnt;

   logic              cur_bit;
   logic [7:0]        new_hist;
   logic [3:0]        cnt_inc;
   logic [7:0]        len_mask;
   logic [3:0]        len_in;
   logic              hit;

   always_comb begin
      cur_bit  = sreg[bit_idx];
      new_hist = {hist[6:0], cur_bit};
      cnt_inc  = hist_cnt + 4'd1;
      len_mask = 8'hFF >> (4'd8 - len);
      // cnt_inc counts the bit being consumed, so a match needs len bits of history including it
      hit      = (state == SHIFT) && (cnt_inc >= len) &&
                 ((new_hist & len_mask) == (pattern & len_mask));
      if (cfg_len < 4'd2)
         len_in = 4'd2;
      else if (cfg_len > 4'd8)
         len_in = 4'd8;
      else
         len_in = cfg_len;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= IDLE;
         sreg           <= '0;
         bit_idx        <= '0;
         pattern        <= 8'h0A;
         len            <= 4'd4;
         overlap        <= 1'b1;
         hist           <= '0;
         hist_cnt       <= '0;
         in_if.in_ready <= 1'b0;
         det_pulse      <= 1'b0;
         match_cnt      <= '0;
         busy           <= 1'b0;
`ifdef SEQ_DET_IRQ_EN
         irq            <= 1'b0;
`endif
      end else begin
         det_pulse <= 1'b0;
         case (state)
            IDLE: begin
               in_if.in_ready <= 1'b1;
               if (cfg_we) begin
                  pattern  <= cfg_pattern;
                  len      <= len_in;
                  overlap  <= cfg_overlap;
                  hist     <= '0;
                  hist_cnt <= '0;
               end
               if (in_if.in_valid && in_if.in_ready) begin
                  sreg           <= in_if.in_data;
                  bit_idx        <= IDX_TOP;
                  state          <= SHIFT;
                  in_if.in_ready <= 1'b0;
                  busy           <= 1'b1;
               end
            end
            SHIFT: begin
               hist <= new_hist;
               if (hit && !overlap)
                  hist_cnt <= 4'd0;
               else if (cnt_inc > 4'd8)
                  hist_cnt <= 4'd8;
               else
                  hist_cnt <= cnt_inc;
               if (hit) begin
                  det_pulse <= 1'b1;
                  if (match_cnt != CNT_MAX)
                     match_cnt <= match_cnt + CNT_W'(1);
               end
               bit_idx <= bit_idx - IDX_W'(1);
               if (bit_idx == '0) begin
                  state          <= IDLE;
                  in_if.in_ready <= 1'b1;
                  busy           <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
`ifdef SEQ_DET_IRQ_EN
         // only an actual increment onto the threshold sets irq; a saturated count does not re-fire
         if (hit && (match_cnt != CNT_MAX) && (irq_thresh != '0) &&
             ((match_cnt + CNT_W'(1)) == irq_thresh))
            irq <= 1'b1;
         else if (irq_clr)
            irq <= 1'b0;
`endif
      end
   end
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb/tb_seq_det_ctrl.sv - directed and randomized bench for seq_det_ctrl against a bit-queue model
module tb_seq_det_ctrl;
   localparam int WORD_W  = 8;
   localparam int CNT_W   = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_we;
   logic [7:0]       cfg_pattern;
   logic [3:0]       cfg_len;
   logic             cfg_overlap;
   logic             det_pulse;
   logic [CNT_W-1:0] match_cnt;
   logic             busy;
   logic [CNT_W-1:0] irq_thresh;
   logic             irq_clr;
`ifdef SEQ_DET_IRQ_EN
   logic             irq;
`endif

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   seq_det_ctrl_if #(.WORD_W(WORD_W)) bus ();

   seq_det_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
      .clk(clk),
      .rst(rst),
      .cfg_we(cfg_we),
      .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len),
      .cfg_overlap(cfg_overlap),
      .in_if(bus),
      .det_pulse(det_pulse),
      .match_cnt(match_cnt),
      .busy(busy)
`ifdef SEQ_DET_IRQ_EN
      ,
      .irq_thresh(irq_thresh),
      .irq_clr(irq_clr),
      .irq(irq)
`endif
   );

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic int clamp_len(input logic [3:0] l);
      if (l < 4'd2) return 2;
      if (l > 4'd8) return 8;
      return int'(l);
   endfunction

   // Model: pending bits of the current word, and the history since the last clear as a plain bit list
   int       m_pend[$];
   int       m_hist[$];
   int       m_pat  = 8'h0A;
   int       m_len  = 4;
   bit       m_ovl  = 1'b1;
   int       m_cnt  = 0;
   bit       m_pulse = 1'b0;
   bit       m_ready = 1'b0;
   bit       m_irq  = 1'b0;
   bit       chk_en = 1'b0;
   int       mb, mv;
   bit       mhit, mset;

   always @(posedge clk) begin
      chk_en = 1'b1;
      if (!rst) begin
         m_pend.delete();
         m_hist.delete();
         m_pat = 8'h0A; m_len = 4; m_ovl = 1'b1;
         m_cnt = 0; m_pulse = 1'b0; m_ready = 1'b0; m_irq = 1'b0;
      end else begin
         m_pulse = 1'b0;
         mset    = 1'b0;
         if (m_pend.size() == 0) begin
            if (cfg_we) begin
               m_pat = int'(cfg_pattern); m_len = clamp_len(cfg_len); m_ovl = cfg_overlap;
               m_hist.delete();
            end
            if (bus.in_valid && m_ready)
               for (int i = WORD_W - 1; i >= 0; i--) m_pend.push_back(int'(bus.in_data[i]));
         end else begin
            mb = m_pend.pop_front();
            m_hist.push_back(mb);
            if (m_hist.size() > 8) void'(m_hist.pop_front());
            mhit = 1'b0;
            if (m_hist.size() >= m_len) begin
               mv = 0;
               for (int i = m_hist.size() - m_len; i < m_hist.size(); i++) mv = mv * 2 + m_hist[i];
               mhit = (mv == (m_pat % (1 << m_len)));
            end
            if (mhit) begin
               m_pulse = 1'b1;
               if (m_cnt < CNT_MAX) begin
                  m_cnt++;
                  mset = (irq_thresh != 0) && (m_cnt == int'(irq_thresh));
               end
               if (!m_ovl) m_hist.delete();
            end
         end
         if (mset) m_irq = 1'b1;
         else if (irq_clr) m_irq = 1'b0;
         m_ready = (m_pend.size() == 0);
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("det_pulse", int'(det_pulse), int'(m_pulse));
         chk("match_cnt", int'(match_cnt), m_cnt);
         chk("busy", int'(busy), int'(m_pend.size() != 0));
         chk("in_ready", int'(bus.in_ready), int'(m_ready));
`ifdef SEQ_DET_IRQ_EN
         chk("irq", int'(irq), int'(m_irq));
`endif
      end
   end

   task automatic do_cfg(input logic [7:0] p, input logic [3:0] l, input bit o);
      cfg_we = 1'b1; cfg_pattern = p; cfg_len = l; cfg_overlap = o;
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   // Bit k of pmask/rmask holds det_pulse/in_ready in the k-th cycle after the handshake cycle
   task automatic send_word(input logic [7:0] w, input int cfg_at, output int pmask, output int rmask);
      int guard;
      guard = 0; pmask = 0; rmask = 0;
      while (bus.in_ready !== 1'b1 && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (bus.in_ready !== 1'b1) chk("handshake_wait", 0, 1);
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         if (k == 1) bus.in_valid = 1'b0;
         cfg_we = (k == cfg_at);
         if (k == cfg_at) begin
            cfg_pattern = 8'hFF; cfg_len = 4'd8;
         end
         pmask |= int'(det_pulse) << k;
         rmask |= int'(bus.in_ready) << k;
      end
   endtask

   int pm, rm, pulses;
   logic [7:0] pick;

   initial begin
      rst = 1'b0; cfg_we = 1'b0; cfg_pattern = '0; cfg_len = '0; cfg_overlap = 1'b0;
      bus.in_valid = 1'b0; bus.in_data = '0; irq_thresh = CNT_W'(2); irq_clr = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_det_pulse", int'(det_pulse), 0);
      chk("rst_match_cnt", int'(match_cnt), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_in_ready", int'(bus.in_ready), 0);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_release", int'(bus.in_ready), 1);

      send_word(8'hAA, 0, pm, rm);
      chk("aa_pulse_cycles", pm, 672);
      chk("aa_ready_cycles", rm, 1536);
      chk("aa_count", int'(match_cnt), 3);
      chk("model_aa_count", m_cnt, 3);
`ifdef SEQ_DET_IRQ_EN
      chk("aa_irq", int'(irq), 1);
`endif

      do_cfg(8'h0A, 4'd4, 1'b0);
      send_word(8'hAA, 0, pm, rm);
      chk("nonoverlap_pulse_cycles", pm, 544);
      chk("nonoverlap_count", int'(match_cnt), 5);

      do_cfg(8'h0A, 4'd4, 1'b1);
      send_word(8'h02, 0, pm, rm);
      chk("cross_word1_pulses", pm, 0);
      send_word(8'h80, 0, pm, rm);
      chk("cross_word2_pulses", pm, 8);
      chk("cross_count", int'(match_cnt), 6);

      send_word(8'hAA, 2, pm, rm);
      chk("cfg_in_shift_pulses", pm, 672);
      chk("cfg_in_shift_count", int'(match_cnt), 9);

      do_cfg(8'h02, 4'd0, 1'b1);
      send_word(8'hAA, 0, pm, rm);
      chk("len_low_clamp_pulses", pm, 680);
      chk("len_low_clamp_count", int'(match_cnt), 13);

      do_cfg(8'hAA, 4'd15, 1'b1);
      send_word(8'hAA, 0, pm, rm);
      chk("len_high_clamp_pulses", pm, 512);
      chk("model_len_high_count", m_cnt, 14);

      bus.in_valid = 1'b1; bus.in_data = 8'hAA;
      @(negedge clk);
      bus.in_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      chk("midreset_pulse", int'(det_pulse), 0);
      chk("midreset_count", int'(match_cnt), 0);
      chk("midreset_ready", int'(bus.in_ready), 0);
      @(negedge clk);
      chk("midreset_ready_release", int'(bus.in_ready), 1);
      chk("midreset_busy", int'(busy), 0);

      pulses = 0;
      repeat (10) begin
         send_word(8'hAA, 0, pm, rm);
         pulses += $countones(pm);
      end
      chk("sat_pulse_total", pulses, 39);
      chk("sat_count", int'(match_cnt), CNT_MAX);

      for (int c = 0; c < 3000; c++) begin
         rst         = ($urandom_range(0, 149) != 0);
         cfg_we      = ($urandom_range(0, 9) == 0);
         cfg_pattern = 8'($urandom);
         cfg_len     = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 5)) : 4'($urandom);
         cfg_overlap = 1'($urandom);
         irq_clr     = ($urandom_range(0, 15) == 0);
         if (c % 500 == 0) irq_thresh = CNT_W'($urandom_range(0, CNT_MAX));
         case ($urandom_range(0, 4))
            0: pick = 8'hAA;
            1: pick = 8'h55;
            2: pick = 8'hF0;
            3: pick = 8'h0F;
            default: pick = 8'($urandom);
         endcase
         bus.in_valid = 1'($urandom);
         bus.in_data  = pick;
         @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/seq_det_ctrl.md
Name: seq_det_ctrl

Overview:
- Word-fed controller for a serial pattern detector. Accepts parallel words over a valid/ready handshake and serialises them MSB-first, one bit per clock.
- Tracks a configurable 2..8-bit pattern, either overlapping or non-overlapping, and counts matches.
- Sits between a word-wide producer and status logic. The default configuration reproduces the team's 1010 detector behaviour.

Parameters:
- WORD_W, 8, width of input words (2..32).
- CNT_W, 16, width of the saturating match counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-low reset (rst==0 at a clk edge resets the block).
- cfg_we  in  1  config write strobe; accepted only in IDLE.
- cfg_pattern  in  8  pattern; only the low cfg_len bits are used; bit 0 is the last bit received.
- cfg_len  in  4  pattern length; values <2 are stored as 2, values >8 are stored as 8.
- cfg_overlap  in  1  1 = overlapping detection, 0 = history cleared after each match.
- in_valid  in  1  input word valid.
- in_data  in  WORD_W  input word; MSB is serialised first.
- in_ready  out  1  high in IDLE only.
- det_pulse  out  1  one-cycle pulse per match.
- match_cnt  out  CNT_W  saturating match count.
- busy  out  1  high in SHIFT.

Behaviour:
- Reset values:
  - in_ready=0 on the reset cycle, then 1 in IDLE.
  - det_pulse=0, match_cnt=0, busy=0, state=IDLE.
  - pattern=8'h0A, len=4, overlap=1.
  - hist=0, hist_cnt=0.
- FSM, 2 states:
  - IDLE: in_ready=1. If in_valid and in_ready, latch in_data into the shift register, set bit_idx=WORD_W-1, go to SHIFT.
  - SHIFT: each cycle consume bit sreg[bit_idx] and decrement bit_idx. When bit_idx==0, return to IDLE.
  - Throughput is one word per WORD_W+1 cycles. There is no new handshake during SHIFT.
- Per consumed bit b:
  - hist <= {hist[6:0], b}.
  - hist_cnt <= min(hist_cnt+1, 8).
  - Match when (hist_cnt+1) >= len and the low len bits of the new hist equal the low len bits of pattern.
- Match actions:
  - det_pulse is registered high in the cycle after the bit is consumed.
  - match_cnt increments in that same cycle and saturates at 2^CNT_W-1.
  - If overlap==0, hist_cnt <= 0 on a match, so following bits start fresh.
- History (hist, hist_cnt) persists across word boundaries and across IDLE gaps. It is cleared only by reset or by an accepted cfg_we.
- cfg_we in IDLE:
  - Loads pattern, len and overlap; clears hist and hist_cnt; match_cnt is kept.
  - If cfg_we and the in_valid handshake occur in the same cycle, both are accepted. The new config applies to that word.
- cfg_we during SHIFT is ignored; there is no queueing.
- Reset mid-SHIFT abandons the word: no det_pulse, and all state returns to reset values on the next cycle.
- All outputs are registered. There is no combinational path from the inputs to det_pulse.

Optional Feature:
- Macro: SEQ_DET_IRQ_EN.
- With the macro defined, three ports are added:
  - irq_thresh  in  CNT_W  match-count threshold.
  - irq_clr  in  1  clears irq.
  - irq  out  1  sticky interrupt.
- irq behaviour:
  - irq sets on the cycle match_cnt becomes equal to irq_thresh (a nonzero threshold only).
  - It stays high until irq_clr=1.
  - If set and clear occur in the same cycle, set wins.
  - irq resets to 0.
- Without the macro, these ports and the logic behind them are absent. Behaviour is otherwise identical.

Test Plan:
- Default config, overlap, word 8'hAA -> det_pulse after bit indices 3, 5 and 7 (cycles 5, 7, 9 after the handshake cycle); match_cnt=3; in_ready returns to 1 after 8 SHIFT cycles.
- cfg_we with pattern=4'b1010, len=4, overlap=0, then word 8'hAA -> pulses after bits 3 and 7 only; match_cnt=2.
- Default config, word 8'h02 then word 8'h80 -> cross-word match on the 2nd bit of word 2; match_cnt=1.
- cfg_we during SHIFT with pattern=8'hFF -> ignored; the 1010 matches continue. Reset (rst=0) at bit 2 of 8'hAA -> no pulse; match_cnt=0; in_ready=1 one cycle after release.
- CNT_W=3, stream ten 8'hAA words with default config -> match_cnt sticks at 7; det_pulse still pulses.
- SEQ_DET_IRQ_EN, irq_thresh=2, word 8'hAA -> irq rises with the 2nd det_pulse. irq_clr asserted together with a match that sets irq -> irq stays 1.
